// File: rtl/udp_receiver.sv
// UDP receive path: parses the 8-byte header, filters on destination port and
// forwards exactly length-8 payload bytes, discarding any trailing padding.
module udp_receiver #(
    parameter logic [15:0] LOCAL_PORT = 16'd5001
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  udp_data,
    input  logic        udp_valid,
    output logic [7:0]  payload_data,
    output logic        payload_valid,
    output logic        payload_last,
    output logic [15:0] src_port,
    output logic [15:0] udp_len,
    output logic        rx_done,
    output logic        rx_error,
    output logic [1:0]  err_code
);

    typedef enum logic [2:0] {
        SYNC,
        IDLE,
        HDR,
        PAYLOAD,
        DRAIN
    } state_t;

    localparam logic [1:0] ERR_PORT  = 2'b01;
    localparam logic [1:0] ERR_SHORT = 2'b10;
    localparam logic [1:0] ERR_TRUNC = 2'b11;

    state_t      state;
    state_t      state_next;
    logic [2:0]  hdr_cnt;
    logic [15:0] dst_port;
    logic [15:0] pay_cnt;

    logic [2:0]  hdr_cnt_n;
    logic [15:0] dst_port_n;
    logic [15:0] pay_cnt_n;
    logic [7:0]  payload_data_n;
    logic        payload_valid_n;
    logic        payload_last_n;
    logic [15:0] src_port_n;
    logic [15:0] udp_len_n;
    logic        rx_done_n;
    logic        rx_error_n;
    logic [1:0]  err_code_n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= SYNC;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            SYNC: begin
                if (!udp_valid) state_next = IDLE;
            end
            IDLE: begin
                if (udp_valid) state_next = HDR;
            end
            HDR: begin
                if (!udp_valid) begin
                    state_next = IDLE;
                end else if (hdr_cnt == 3'd7) begin
                    if ((udp_len <= 16'd8) || (dst_port != LOCAL_PORT)) begin
                        state_next = DRAIN;
                    end else begin
                        state_next = PAYLOAD;
                    end
                end
            end
            PAYLOAD: begin
                if (!udp_valid) begin
                    state_next = IDLE;
                end else if (pay_cnt == 16'd1) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (!udp_valid) state_next = IDLE;
            end
            default: state_next = SYNC;
        endcase
    end

    // Next values for every registered output and the parse datapath.
    // The byte-7 length check uses udp_len, already complete by then.
    always_comb begin
        hdr_cnt_n       = hdr_cnt;
        dst_port_n      = dst_port;
        pay_cnt_n       = pay_cnt;
        payload_data_n  = payload_data;
        payload_valid_n = 1'b0;
        payload_last_n  = 1'b0;
        src_port_n      = src_port;
        udp_len_n       = udp_len;
        rx_done_n       = 1'b0;
        rx_error_n      = 1'b0;
        err_code_n      = err_code;
        case (state)
            IDLE: begin
                if (udp_valid) begin
                    src_port_n = {udp_data, src_port[7:0]};
                    hdr_cnt_n  = 3'd1;
                end
            end
            HDR: begin
                if (!udp_valid) begin
                    rx_error_n = 1'b1;
                    err_code_n = ERR_TRUNC;
                end else begin
                    hdr_cnt_n = hdr_cnt + 3'd1;
                    case (hdr_cnt)
                        3'd1: src_port_n = {src_port[15:8], udp_data};
                        3'd2: dst_port_n = {udp_data, dst_port[7:0]};
                        3'd3: dst_port_n = {dst_port[15:8], udp_data};
                        3'd4: udp_len_n  = {udp_data, udp_len[7:0]};
                        3'd5: udp_len_n  = {udp_len[15:8], udp_data};
                        3'd7: begin
                            if (udp_len < 16'd8) begin
                                rx_error_n = 1'b1;
                                err_code_n = ERR_SHORT;
                            end else if (dst_port != LOCAL_PORT) begin
                                rx_error_n = 1'b1;
                                err_code_n = ERR_PORT;
                            end else if (udp_len == 16'd8) begin
                                rx_done_n = 1'b1;
                            end else begin
                                pay_cnt_n = udp_len - 16'd8;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            PAYLOAD: begin
                if (!udp_valid) begin
                    rx_error_n = 1'b1;
                    err_code_n = ERR_TRUNC;
                end else begin
                    payload_data_n  = udp_data;
                    payload_valid_n = 1'b1;
                    pay_cnt_n       = pay_cnt - 16'd1;
                    if (pay_cnt == 16'd1) begin
                        payload_last_n = 1'b1;
                        rx_done_n      = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hdr_cnt       <= 3'd0;
            dst_port      <= 16'd0;
            pay_cnt       <= 16'd0;
            payload_data  <= 8'd0;
            payload_valid <= 1'b0;
            payload_last  <= 1'b0;
            src_port      <= 16'd0;
            udp_len       <= 16'd0;
            rx_done       <= 1'b0;
            rx_error      <= 1'b0;
            err_code      <= 2'd0;
        end else begin
            hdr_cnt       <= hdr_cnt_n;
            dst_port      <= dst_port_n;
            pay_cnt       <= pay_cnt_n;
            payload_data  <= payload_data_n;
            payload_valid <= payload_valid_n;
            payload_last  <= payload_last_n;
            src_port      <= src_port_n;
            udp_len       <= udp_len_n;
            rx_done       <= rx_done_n;
            rx_error      <= rx_error_n;
            err_code      <= err_code_n;
        end
    end

endmodule
